seq_stage_controller: RTL

Multi-cycle control sequencer for the Y86-64 SEQ core. It replaces the free-running combinational PC loop with an explicit stage FSM that owns the PC register, issues one-hot enables to the fetch, decode, execute, memory, writeback and PC-update blocks, and maintains the architectural status (AOK/HLT/ADR/INS). It adds a data-memory ready handshake, error-driven halt and a retired-instruction counter.

---
 rtl/seq_stage_controller_if.sv | 45 ++++
 rtl/seq_stage_controller.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/seq_stage_controller_if.sv
// Datapath-facing bus of the Y86-64 SEQ stage controller.
// The step input exists only when SEQ_SINGLE_STEP_EN is defined.
interface seq_stage_controller_if #(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 32
);
    logic              run;
    logic [3:0]        icode;
    logic              instruction_valid;
    logic              imem_error;
    logic              dmem_error;
    logic              mem_ready;
    logic [ADDR_W-1:0] new_pc;
`ifdef SEQ_SINGLE_STEP_EN
    logic              step;
`endif
    logic [ADDR_W-1:0] pc;
    logic              fetch_en;
    logic              decode_en;
    logic              execute_en;
    logic              memory_en;
    logic              writeback_en;
    logic              pcupd_en;
    logic [2:0]        stat;
    logic              halted;
    logic [CNT_W-1:0]  instr_count;

    modport master (
        output run, icode, instruction_valid, imem_error, dmem_error, mem_ready, new_pc,
`ifdef SEQ_SINGLE_STEP_EN
        output step,
`endif
        input  pc, fetch_en, decode_en, execute_en, memory_en, writeback_en, pcupd_en,
        input  stat, halted, instr_count
    );

    modport slave (
        input  run, icode, instruction_valid, imem_error, dmem_error, mem_ready, new_pc,
`ifdef SEQ_SINGLE_STEP_EN
        input  step,
`endif
        output pc, fetch_en, decode_en, execute_en, memory_en, writeback_en, pcupd_en,
        output stat, halted, instr_count
    );
endinterface

// File: rtl/seq_stage_controller.sv
// Multi-cycle stage sequencer for the Y86-64 SEQ core: owns PC, stage enables, status and retire count.
// Optional single-step mode (PAUSE state, step input) is built when SEQ_SINGLE_STEP_EN is defined.
module seq_stage_controller #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 32
) (
    input logic                    clk,
    input logic                    rst,
    seq_stage_controller_if.slave  bus
);
    // state     | meaning
    // IDLE      | stopped, waiting for run
    // FETCH     | fetch_en; classify instruction status
    // DECODE    | decode_en
    // EXECUTE   | execute_en
    // MEMORY    | memory_en; wait for mem_ready
    // WRITEBACK | writeback_en
    // PCUPDATE  | pcupd_en; load new_pc, retire
    // HALT      | terminal until reset
    // PAUSE     | single-step hold, waiting for step
    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_PCUPDATE,
`ifdef SEQ_SINGLE_STEP_EN
        S_PAUSE,
`endif
        S_HALT
    } state_t;

    localparam logic [2:0]       STAT_AOK = 3'd1;
    localparam logic [2:0]       STAT_HLT = 3'd2;
    localparam logic [2:0]       STAT_ADR = 3'd3;
    localparam logic [2:0]       STAT_INS = 3'd4;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        stat_q, stat_d;
    logic [5:0]        en_q, en_d;
    logic              halted_q, halted_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            cnt_q    <= '0;
            stat_q   <= STAT_AOK;
            en_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            stat_q   <= stat_d;
            en_q     <= en_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        stat_d  = stat_q;
        case (state_q)
            S_IDLE: begin
                if (bus.run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.imem_error) begin
                    stat_d  = STAT_ADR;
                    state_d = S_HALT;
                end else if (!bus.instruction_valid) begin
                    stat_d  = STAT_INS;
                    state_d = S_HALT;
                end else if (bus.icode == 4'h0) begin
                    stat_d  = STAT_HLT;
                    state_d = S_HALT;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE:  state_d = S_EXECUTE;
            S_EXECUTE: state_d = S_MEMORY;
            S_MEMORY: begin
                if (bus.mem_ready) begin
                    if (bus.dmem_error) begin
                        stat_d  = STAT_ADR;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: state_d = S_PCUPDATE;
            S_PCUPDATE: begin
                pc_d  = bus.new_pc;
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
                state_d = bus.run ? S_PAUSE : S_IDLE;
`else
                state_d = bus.run ? S_FETCH : S_IDLE;
`endif
            end
`ifdef SEQ_SINGLE_STEP_EN
            S_PAUSE: begin
                if (!bus.run)     state_d = S_IDLE;
                else if (bus.step) state_d = S_FETCH;
            end
`endif
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Enables are registered from the next state so they line up with state_q without output glitches.
    always_comb begin
        en_d     = '0;
        halted_d = (state_d == S_HALT);
        case (state_d)
            S_FETCH:     en_d[0] = 1'b1;
            S_DECODE:    en_d[1] = 1'b1;
            S_EXECUTE:   en_d[2] = 1'b1;
            S_MEMORY:    en_d[3] = 1'b1;
            S_WRITEBACK: en_d[4] = 1'b1;
            S_PCUPDATE:  en_d[5] = 1'b1;
            default:     en_d    = '0;
        endcase
    end

    assign bus.pc           = pc_q;
    assign bus.fetch_en     = en_q[0];
    assign bus.decode_en    = en_q[1];
    assign bus.execute_en   = en_q[2];
    assign bus.memory_en    = en_q[3];
    assign bus.writeback_en = en_q[4];
    assign bus.pcupd_en     = en_q[5];
    assign bus.stat         = stat_q;
    assign bus.halted       = halted_q;
    assign bus.instr_count  = cnt_q;
endmodule
